nx_ram_port_ctrl: RTL

NX_RAM_PORT_CTRL -- requirements
Module: nx_ram_port_ctrl

---
 rtl/nx_ram_port_ctrl_pkg.sv | 15 +
 rtl/nx_ram_rsp_fifo.sv | 81 ++++++++
 rtl/nx_ram_port_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/nx_ram_port_ctrl_pkg.sv
// Shared types and helpers for the RAM port controller.
package nx_ram_port_ctrl_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Number of write-enable lanes: one per byte when byte writes are on, else one.
  function automatic int unsigned wstrb_width(input int unsigned byte_wr_en,
                                              input int unsigned data_width);
    return (byte_wr_en != 0) ? (data_width / 8) : 1;
  endfunction

endpackage

// File: rtl/nx_ram_rsp_fifo.sv
// Response buffer: circular store with registered pointers and occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module nx_ram_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk_a,
  input  logic             i_rst_a,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Next-state pointers and occupancy; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = i_pop && (count_q != '0);
    if (i_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (i_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!i_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; no reset needed because occupancy gates what is visible.
  always_ff @(posedge i_clk_a) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

`ifndef SYNTHESIS
  // Upstream credit logic keeps pushes from ever landing on a full buffer.
  always_ff @(posedge i_clk_a) begin
    if (!i_rst_a) begin
      assert (!(i_push && !do_pop && (count_q == FULL_CNT)))
        else $error("nx_ram_rsp_fifo overflow");
    end
  end
`endif

  assign o_valid = (count_q != '0);
  assign o_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

endmodule

// File: rtl/nx_ram_port_ctrl.sv
// Request/response front end for a single synchronous RAM port.
// Reads are tracked through a valid pipe matching RAM latency and land in
// an in-order response buffer; writes complete silently.
module nx_ram_port_ctrl
  import nx_ram_port_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int REGISTER_RD   = 0,
  parameter int BYTE_WR_EN    = 0,
  parameter int RSP_DEPTH     = 4,
  localparam int WSTRB_WIDTH  = int'(wstrb_width(BYTE_WR_EN, DATA_WIDTH))
) (
  input  logic                     i_clk_a,
  input  logic                     i_rst_a,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wr_data,
  input  logic [WSTRB_WIDTH-1:0]   i_req_wr_strb,
  input  logic                     i_req_write,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_rd_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]    o_ram_wr_data,
  output logic [WSTRB_WIDTH-1:0]   o_ram_wr_en,
  output logic                     o_ram_en,
  input  logic [DATA_WIDTH-1:0]    i_ram_rd_data,
  output logic                     o_idle
);

  localparam int L     = 1 + REGISTER_RD;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(RSP_DEPTH);

  logic [L-1:0]     rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   used;
  logic             accept;
  logic             accept_rd;
  logic             is_write;
  logic             rsp_pop;

  // Credit check and RAM drive; ready depends only on registered occupancy.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) begin
      inflight = inflight + CNT_W'(rd_vld_q[i]);
    end
    used          = {1'b0, inflight} + {1'b0, fifo_count};
    o_req_ready   = !i_rst_a && (used < DEPTH_LIM);
    accept        = i_req_valid && o_req_ready;
    is_write      = (op_e'(i_req_write) == OP_WRITE);
    accept_rd     = accept && !is_write;
    o_ram_en      = accept && (!is_write || (|i_req_wr_strb));
    o_ram_wr_en   = (accept && is_write) ? i_req_wr_strb : '0;
    o_ram_addr    = i_req_addr;
    o_ram_wr_data = i_req_wr_data;
    o_idle        = (inflight == '0) && (fifo_count == '0);
  end

  // Read-tracking pipe: the last stage marks the cycle RAM data is valid.
  always_comb begin
    rd_vld_d    = '0;
    rd_vld_d[0] = accept_rd;
    for (int i = 1; i < L; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end
  end

  // Read-tracking pipe state; reset drops every in-flight read.
  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rsp_pop = o_rsp_valid && i_rsp_ready;

  nx_ram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk_a     (i_clk_a),
    .i_rst_a     (i_rst_a),
    .i_push      (rd_vld_q[L-1]),
    .i_push_data (i_ram_rd_data),
    .i_pop       (rsp_pop),
    .o_valid     (o_rsp_valid),
    .o_data      (o_rsp_rd_data),
    .o_count     (fifo_count)
  );

endmodule
